// File: rtl/regfile_pkg.sv
// Shared types for the register-file access controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package regfile_pkg;

    typedef enum logic [1:0] {
        RF_READ  = 2'd0,
        RF_WRITE = 2'd1,
        RF_ADD   = 2'd2,
        RF_CLEAR = 2'd3
    } rf_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_RESP  = 2'd3
    } rf_state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for a single-port register file: READ, WRITE, fetch-and-ADD, CLEAR_ALL.
// Latency: accept->rsp_valid 2 cycles (READ/WRITE/ADD), 1 cycle (out-of-range), N+1 cycles (CLEAR).
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until rsp_ready.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cmd_valid/cmd_ready/op/addr/data    command channel
//   rsp_valid/rsp_ready/rsp_data/err    response channel
//   busy                                controller not idle
//   rf_read_addr / rf_read_data         combinational read port of the storage
//   rf_write_en/addr/data               synchronous write port of the storage
module regfile_access_ctrl
    import regfile_pkg::*;
#(
    parameter  int N      = 32,
    parameter  int DWIDTH = 32,
    localparam int AW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [DWIDTH-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [AW-1:0]     rf_read_addr,
    input  logic [DWIDTH-1:0] rf_read_data,
    output logic              rf_write_en,
    output logic [AW-1:0]     rf_write_addr,
    output logic [DWIDTH-1:0] rf_write_data
);

    // One extra bit so N itself is representable when N is a power of two.
    localparam logic [AW:0]   N_EXT = (AW+1)'(N);
    localparam logic [AW-1:0] LAST  = AW'(N - 1);

    rf_state_e         state;
    rf_op_e            op_q;
    logic [AW-1:0]     idx_q;   // latched address in EXEC, sweep counter in CLEAR
    logic [DWIDTH-1:0] data_q;
    logic [DWIDTH-1:0] rsp_data_q;
    logic              rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= RF_READ;
            idx_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= rf_op_e'(cmd_op);
                        data_q <= cmd_data;
                        if (rf_op_e'(cmd_op) == RF_CLEAR) begin
                            idx_q <= '0;
                            state <= ST_CLEAR;
                        end else if ({1'b0, cmd_addr} >= N_EXT) begin
                            // Rejected: answer straight away, storage untouched.
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            idx_q <= cmd_addr;
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // All three ops return the content seen before this cycle's write.
                    rsp_data_q <= rf_read_data;
                    rsp_err_q  <= 1'b0;
                    state      <= ST_RESP;
                end
                ST_CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    assign rf_read_addr  = idx_q;
    assign rf_write_addr = idx_q;

    always_comb begin
        rf_write_en   = 1'b0;
        rf_write_data = '0;
        if (state == ST_CLEAR) begin
            rf_write_en = 1'b1;
        end else if (state == ST_EXEC) begin
            if (op_q == RF_WRITE) begin
                rf_write_en   = 1'b1;
                rf_write_data = data_q;
            end else if (op_q == RF_ADD) begin
                rf_write_en   = 1'b1;
                rf_write_data = rf_read_data + data_q;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: directed scenarios plus random commands against an array model.
// Latency: checks accept->response cycle counts and per-cycle write-port activity.
// Backpressure: holds rsp_ready low for random stretches and checks the response stays put.
module tb_regfile_access_ctrl;

    localparam int N  = 24;
    localparam int DW = 32;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] rf_read_addr;
    logic [DW-1:0] rf_read_data;
    logic          rf_write_en;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;

    regfile_access_ctrl #(.N(N), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    // Storage instance stand-in: combinational read, write on clock edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign rf_read_data = mem[rf_read_addr];
    always @(posedge clk) begin
        if (rf_write_en) mem[rf_write_addr] <= rf_write_data;
    end

    // Reference model of the register file contents.
    logic [DW-1:0] ref_mem [0:N-1];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one command (caller is at a negedge), follow it to its response handshake.
    task automatic do_cmd(input logic [1:0] op, input int addr, input logic [31:0] d, input int hold);
        logic [31:0] exp_d, new_val;
        logic        exp_e;
        int          exp_lat, cyc;
        exp_e = 1'b0; exp_d = '0; new_val = '0;
        if (op == 2'd3) begin
            exp_lat = N + 1;
            for (int i = 0; i < N; i++) ref_mem[i] = '0;
        end else if (addr >= N) begin
            exp_e = 1'b1; exp_lat = 1;
        end else begin
            exp_lat = 2;
            exp_d   = ref_mem[addr];
            if (op == 2'd1) new_val = d;
            if (op == 2'd2) new_val = ref_mem[addr] + d;
            if (op != 2'd0) ref_mem[addr] = new_val;
        end

        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = AW'(addr); cmd_data = d; rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;
        forever begin
            if (op == 2'd3 && cyc <= N) begin
                chk("clr_we", 32'(rf_write_en), 32'd1);
                chk("clr_waddr", 32'(rf_write_addr), 32'(cyc - 1));
                chk("clr_wdata", rf_write_data, 32'd0);
            end else if (exp_e) begin
                chk("err_no_we", 32'(rf_write_en), 32'd0);
            end else if (op != 2'd3 && cyc == 1) begin
                chk("exec_raddr", 32'(rf_read_addr), 32'(addr));
                chk("exec_we", 32'(rf_write_en), 32'(op != 2'd0));
                if (op != 2'd0) begin
                    chk("exec_waddr", 32'(rf_write_addr), 32'(addr));
                    chk("exec_wdata", rf_write_data, new_val);
                end
            end
            if (rsp_valid) break;
            if (cyc > exp_lat + 4) begin
                chk("rsp_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rsp_latency", 32'(cyc), 32'(exp_lat));
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_err", 32'(rsp_err), 32'(exp_e));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", rsp_data, exp_d);
            chk("hold_err", 32'(rsp_err), 32'(exp_e));
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_we", 32'(rf_write_en), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(rf_write_en), 32'd0);
        chk("rst_raddr", 32'(rf_read_addr), 32'd0);
        chk("rst_waddr", 32'(rf_write_addr), 32'd0);
        chk("rst_wdata", rf_write_data, 32'd0);
    endtask

    initial begin
        logic [1:0] op;
        int r;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values();

        // Write then read back, back-to-back at minimum spacing.
        do_cmd(2'd1, 3, 32'h0000_0005, 0);
        do_cmd(2'd0, 3, 32'hDEAD_BEEF, 0);
        // Fetch-and-add wrap.
        do_cmd(2'd1, 7, 32'hFFFF_FFFE, 0);
        do_cmd(2'd2, 7, 32'h0000_0003, 0);
        do_cmd(2'd0, 7, 32'h0, 0);
        // Fill with 0xA5, clear, read a few back.
        for (int i = 0; i < N; i++) do_cmd(2'd1, i, 32'h0000_00A5, 0);
        do_cmd(2'd3, 0, 32'h1234_5678, 0);
        do_cmd(2'd0, 0, 32'h0, 0);
        do_cmd(2'd0, N - 1, 32'h0, 0);
        // Response backpressure.
        do_cmd(2'd1, 5, 32'hCAFE_F00D, 5);
        do_cmd(2'd0, 5, 32'h0, 5);
        // Out-of-range accesses, including a write that must not land.
        do_cmd(2'd0, 30, 32'h0, 2);
        do_cmd(2'd1, N, 32'h5555_5555, 0);
        do_cmd(2'd0, N - 1, 32'h0, 0);

        // Random traffic.
        for (int k = 0; k < 150; k++) begin
            r  = $urandom_range(0, 19);
            op = (r < 7) ? 2'd0 : (r < 13) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            do_cmd(op, $urandom_range(0, (1 << AW) - 1), $urandom, $urandom_range(0, 3));
        end

        // Reset in the middle of a CLEAR: first four entries already zeroed.
        for (int i = 0; i < N; i++) do_cmd(2'd1, i, $urandom | 32'h1, 0);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_addr = '0; cmd_data = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midclr_we_drop", 32'(rf_write_en), 32'd0);
        chk("midclr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midclr_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values();
        for (int i = 0; i < N; i++) do_cmd(2'd0, i, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
